// File: rtl/mouse_pos_tracker_pkg.sv
// Shared VGA screen constants and PS/2 mouse packet types.
package mouse_pos_tracker_pkg;

  localparam int SCREEN_W = 1024;
  localparam int SCREEN_H = 768;
  localparam int POS_W    = 12;

  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_B1 = 2'd1,
    WAIT_B2 = 2'd2
  } pkt_state_e;

  typedef struct packed {
    logic y_ovf;
    logic x_ovf;
    logic y_sign;
    logic x_sign;
    logic right;
    logic left;
  } mouse_status_t;

endpackage

// File: rtl/mouse_pos_tracker.sv
// PS/2 mouse packet decoder tracking a clamped cursor position; the visible
// position is only refreshed at vertical sync so the cursor never tears.
module mouse_pos_tracker
  import mouse_pos_tracker_pkg::*;
#(
  parameter int TIMEOUT_CYC = 650000,
  parameter int X_MAX       = SCREEN_W - 1,
  parameter int Y_MAX       = SCREEN_H - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             vsync,
  output logic [POS_W-1:0] xpos,
  output logic [POS_W-1:0] ypos,
  output logic             left,
  output logic             right,
  output logic             sync_err
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0]     TO_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic signed [13:0] X_LIM  = 14'(X_MAX);
  localparam logic signed [13:0] Y_LIM  = 14'(Y_MAX);
  localparam logic [POS_W-1:0]   X_RST  = POS_W'(X_MAX / 2);
  localparam logic [POS_W-1:0]   Y_RST  = POS_W'(Y_MAX / 2);

  function automatic logic [POS_W-1:0] clamp(input logic signed [13:0] v,
                                             input logic signed [13:0] lim);
    logic [POS_W-1:0] r;
    if (v < 14'sd0) begin
      r = {POS_W{1'b0}};
    end else if (v > lim) begin
      r = POS_W'(lim);
    end else begin
      r = POS_W'(v);
    end
    return r;
  endfunction

  pkt_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  mouse_status_t    status_q, status_d;
  logic [7:0]       dx_q, dx_d;
  logic [POS_W-1:0] x_q, x_d, y_q, y_d;
  logic [POS_W-1:0] xpos_q, xpos_d, ypos_q, ypos_d;
  logic             left_q, left_d, right_q, right_d;
  logic             sync_err_q, sync_err_d;
  logic             vs_q, vs_d, vs_prev_q, vs_prev_d;
  logic             timeout_s, pkt_done_s;
  logic signed [13:0] x_sum_s, y_sum_s;

  // Next-state logic: packet FSM, idle timeout, position update, vsync load.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    status_d   = status_q;
    dx_d       = dx_q;
    x_d        = x_q;
    y_d        = y_q;
    left_d     = left_q;
    right_d    = right_q;
    xpos_d     = xpos_q;
    ypos_d     = ypos_q;
    sync_err_d = 1'b0;
    vs_d       = vsync;
    vs_prev_d  = vs_q;
    pkt_done_s = 1'b0;
    timeout_s  = (state_q != WAIT_B0) && (cnt_q >= TO_LAST);
    x_sum_s    = $signed({2'b00, x_q}) + $signed({{6{status_q.x_sign}}, dx_q});
    y_sum_s    = $signed({2'b00, y_q}) - $signed({{6{status_q.y_sign}}, rx_data});

    // A timed-out packet behaves as WAIT_B0 so a coincident byte is re-examined as status.
    if ((state_q == WAIT_B0) || timeout_s) begin
      cnt_d      = {CW{1'b0}};
      sync_err_d = timeout_s;
      if (rx_valid && rx_data[3]) begin
        status_d = '{y_ovf:  rx_data[7], x_ovf: rx_data[6], y_sign: rx_data[5],
                     x_sign: rx_data[4], right: rx_data[1], left:  rx_data[0]};
        state_d  = WAIT_B1;
      end else if (rx_valid) begin
        sync_err_d = 1'b1;
        state_d    = WAIT_B0;
      end else begin
        state_d = WAIT_B0;
      end
    end else if (rx_valid) begin
      cnt_d = {CW{1'b0}};
      case (state_q)
        WAIT_B1: begin
          dx_d    = rx_data;
          state_d = WAIT_B2;
        end
        WAIT_B2: begin
          pkt_done_s = 1'b1;
          state_d    = WAIT_B0;
        end
        default: state_d = WAIT_B0;
      endcase
    end else begin
      cnt_d = cnt_q + CW'(1'b1);
    end

    if (pkt_done_s) begin
      x_d     = status_q.x_ovf ? x_q : clamp(x_sum_s, X_LIM);
      y_d     = status_q.y_ovf ? y_q : clamp(y_sum_s, Y_LIM);
      left_d  = status_q.left;
      right_d = status_q.right;
    end else begin
      x_d = x_q;
      y_d = y_q;
    end

    // Loads the pre-update position when a packet completes on the edge cycle.
    if (vs_q && !vs_prev_q) begin
      xpos_d = x_q;
      ypos_d = y_q;
    end else begin
      xpos_d = xpos_q;
      ypos_d = ypos_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= WAIT_B0;
      cnt_q      <= {CW{1'b0}};
      status_q   <= mouse_status_t'(6'd0);
      dx_q       <= 8'd0;
      x_q        <= X_RST;
      y_q        <= Y_RST;
      xpos_q     <= X_RST;
      ypos_q     <= Y_RST;
      left_q     <= 1'b0;
      right_q    <= 1'b0;
      sync_err_q <= 1'b0;
      vs_q       <= 1'b0;
      vs_prev_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      status_q   <= status_d;
      dx_q       <= dx_d;
      x_q        <= x_d;
      y_q        <= y_d;
      xpos_q     <= xpos_d;
      ypos_q     <= ypos_d;
      left_q     <= left_d;
      right_q    <= right_d;
      sync_err_q <= sync_err_d;
      vs_q       <= vs_d;
      vs_prev_q  <= vs_prev_d;
    end
  end

  assign xpos     = xpos_q;
  assign ypos     = ypos_q;
  assign left     = left_q;
  assign right    = right_q;
  assign sync_err = sync_err_q;

endmodule

// File: tb/tb_mouse_pos_tracker.sv
// Self-checking bench: directed vector table, corner sequences and random
// traffic compared against a packet-level reference model.
module tb_mouse_pos_tracker;

  localparam int T = 24;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        vsync;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        left;
  logic        right;
  logic        sync_err;

  int checks;
  int failures;

  mouse_pos_tracker #(.TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .vsync(vsync),
    .xpos(xpos), .ypos(ypos), .left(left), .right(right), .sync_err(sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  int         m_x, m_y, m_xpos, m_ypos, gap;
  bit         m_left, m_right, m_err, m_vs1, m_vs2;
  logic [7:0] pkt[$];

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       vs;
    int         x;
    int         y;
    logic       l;
    logic       r;
    logic       e;
  } vec_t;

  vec_t tbl[18];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  task automatic model_reset();
    m_x = 511; m_y = 383; m_xpos = 511; m_ypos = 383;
    m_left = 1'b0; m_right = 1'b0; m_err = 1'b0;
    m_vs1 = 1'b0; m_vs2 = 1'b0; gap = 0;
    pkt.delete();
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic vs);
    logic [7:0] s;
    int dx, dy;
    m_err = 1'b0;
    if (m_vs1 && !m_vs2) begin
      m_xpos = m_x;
      m_ypos = m_y;
    end
    m_vs2 = m_vs1;
    m_vs1 = vs;
    if (pkt.size() != 0) begin
      gap++;
      if (gap >= T) begin
        pkt.delete();
        m_err = 1'b1;
      end
    end
    if (v) begin
      gap = 0;
      if (pkt.size() == 0) begin
        if (d[3]) pkt.push_back(d);
        else m_err = 1'b1;
      end else begin
        pkt.push_back(d);
      end
      if (pkt.size() == 3) begin
        s  = pkt[0];
        dx = int'(pkt[1]) - (s[4] ? 256 : 0);
        dy = int'(pkt[2]) - (s[5] ? 256 : 0);
        if (!s[6]) m_x = clampi(m_x + dx, 1023);
        if (!s[7]) m_y = clampi(m_y - dy, 767);
        m_left  = s[0];
        m_right = s[1];
        pkt.delete();
      end
    end
  endtask

  task automatic cycle(input logic v, input logic [7:0] d, input logic vs);
    rx_valid = v;
    rx_data  = d;
    vsync    = vs;
    @(posedge clk);
    model_step(v, d, vs);
    #1;
    check("model_xpos", int'(xpos), m_xpos);
    check("model_ypos", int'(ypos), m_ypos);
    check("model_left", int'(left), int'(m_left));
    check("model_right", int'(right), int'(m_right));
    check("model_sync_err", int'(sync_err), int'(m_err));
    rx_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    cycle(1'b1, b0, 1'b0);
    cycle(1'b1, b1, 1'b0);
    cycle(1'b1, b2, 1'b0);
  endtask

  task automatic vs_pulse();
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_xpos"}, int'(xpos), 511);
    check({tag, "_ypos"}, int'(ypos), 383);
    check({tag, "_left"}, int'(left), 0);
    check({tag, "_right"}, int'(right), 0);
    check({tag, "_sync_err"}, int'(sync_err), 0);
  endtask

  initial begin
    int idle_left;
    logic       rv;
    logic [7:0] rd;
    checks = 0; failures = 0;
    rx_valid = 1'b0; rx_data = 8'h00; vsync = 1'b0;

    tbl[0]  = '{1'b0, 8'h00, 1'b0, 511, 383, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 8'h08, 1'b0, 511, 383, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 8'h10, 1'b0, 511, 383, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 8'h05, 1'b0, 511, 383, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 511, 383, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 527, 378, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 8'h19, 1'b0, 527, 378, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 8'hF0, 1'b0, 527, 378, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 8'h00, 1'b0, 527, 378, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 527, 378, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 511, 378, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 8'h00, 1'b0, 511, 378, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 511, 378, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 8'h48, 1'b0, 511, 378, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 8'hFF, 1'b0, 511, 378, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 8'h02, 1'b0, 511, 378, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 8'h00, 1'b1, 511, 378, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 8'h00, 1'b1, 511, 376, 1'b0, 1'b0, 1'b0};

    // reset
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // directed vector table
    for (int i = 0; i < 18; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].vs);
      check($sformatf("tbl%0d_xpos", i), int'(xpos), tbl[i].x);
      check($sformatf("tbl%0d_ypos", i), int'(ypos), tbl[i].y);
      check($sformatf("tbl%0d_left", i), int'(left), int'(tbl[i].l));
      check($sformatf("tbl%0d_right", i), int'(right), int'(tbl[i].r));
      check($sformatf("tbl%0d_sync_err", i), int'(sync_err), int'(tbl[i].e));
    end

    // saturation at the high x edge and the low y edge
    repeat (5) send_pkt(8'h08, 8'h7F, 8'h00);
    vs_pulse();
    check("sat_xpos", int'(xpos), 1023);
    repeat (4) send_pkt(8'h08, 8'h00, 8'h64);
    vs_pulse();
    check("sat_ypos", int'(ypos), 0);
    check("sat_xpos_hold", int'(xpos), 1023);

    // timeout after a lone status byte; next status byte starts a fresh packet
    cycle(1'b1, 8'h08, 1'b0);
    repeat (T - 1) cycle(1'b0, 8'h00, 1'b0);
    check("to_early", int'(sync_err), 0);
    cycle(1'b0, 8'h00, 1'b0);
    check("to_pulse", int'(sync_err), 1);
    cycle(1'b0, 8'h00, 1'b0);
    check("to_pulse_end", int'(sync_err), 0);
    send_pkt(8'h18, 8'hF0, 8'h00);
    vs_pulse();
    check("to_resync_xpos", int'(xpos), 1007);

    // byte coinciding with timeout expiry is taken as a status byte
    cycle(1'b1, 8'h08, 1'b0);
    repeat (T - 1) cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h18, 1'b0);
    check("coinc_err", int'(sync_err), 1);
    cycle(1'b1, 8'hF0, 1'b0);
    cycle(1'b1, 8'h00, 1'b0);
    check("coinc_no_err", int'(sync_err), 0);
    vs_pulse();
    check("coinc_xpos", int'(xpos), 991);

    // reset in the middle of a packet
    cycle(1'b1, 8'h09, 1'b0);
    cycle(1'b1, 8'h10, 1'b0);
    rst = 1'b1;
    model_reset();
    #2;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    send_pkt(8'h08, 8'h10, 8'h05);
    vs_pulse();
    check("midrst_pkt_xpos", int'(xpos), 527);
    check("midrst_pkt_ypos", int'(ypos), 378);
    check("midrst_pkt_left", int'(left), 0);

    // randomized traffic against the reference model
    idle_left = 0;
    for (int i = 0; i < 3000; i++) begin
      rv = 1'b0;
      rd = 8'($urandom_range(0, 255));
      if (idle_left > 0) begin
        idle_left--;
      end else if ($urandom_range(0, 149) == 0) begin
        idle_left = T - 2 + int'($urandom_range(0, 4));
      end else begin
        rv = ($urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 3) != 0) rd[7:6] = 2'b00;
      if ($urandom_range(0, 7) != 0) rd[3] = 1'b1;
      cycle(rv, rd, ((i % 53) < 5) ? 1'b1 : 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
